// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with registered single-cycle ops and iterative MULTU/DIVU.
// Ports: valid/ready in (op_code,in1,in2,shamt), valid/ready out (out,out_hi,zero), flush, busy.
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op_code,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam int SW = (CW < 5) ? CW : 5;
    localparam logic [4:0] SH_MASK = 5'((1 << SW) - 1);

    localparam logic [5:0] OP_ADDU  = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SUBU  = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101001;
    localparam logic [5:0] OP_SLL   = 6'b000010;
    localparam logic [5:0] OP_SRL   = 6'b000011;
    localparam logic [5:0] OP_SRA   = 6'b000111;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // MUL: high partial product; DIV: remainder
    logic [WIDTH-1:0] lo_q, lo_d;     // MUL: multiplier/low word; DIV: dividend/quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             vld_q, vld_d;

    logic             accept;
    logic [4:0]       sh;
    logic [WIDTH-1:0] res;
    logic             is_mul, is_div;

    assign in_ready  = (state_q == S_IDLE) && (!vld_q || out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = vld_q;
    assign out       = out_q;
    assign out_hi    = hi_q;
    assign zero      = zero_q;

    assign sh     = shamt & SH_MASK;
    assign is_mul = MULDIV_EN && (op_code == OP_MULTU);
    assign is_div = MULDIV_EN && (op_code == OP_DIVU);

    always_comb begin
        res = '0;
        case (op_code)
            OP_ADDU, OP_ADDIU, OP_LW, OP_SW: res = in1 + in2;
            OP_BEQ, OP_BNE, OP_SUBU:         res = in1 - in2;
            OP_AND:  res = in1 & in2;
            OP_OR:   res = in1 | in2;
            OP_XOR:  res = in1 ^ in2;
            OP_NOR:  res = ~(in1 | in2);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, in1 < in2};
            OP_SLL:  res = in2 << sh;
            OP_SRL:  res = in2 >> sh;
            OP_SRA:  res = WIDTH'($signed(in2) >>> sh);
            default: res = '0;
        endcase
    end

    // Shift-add step: conditionally add multiplicand to the high half,
    // then shift the {acc,lo} pair right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_n, mul_lo_n;
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_acc_n = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder, subtract
    // divisor if it fits and record the quotient bit.
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_n, div_q_n;
    assign div_sh    = {acc_q, lo_q[WIDTH-1]};
    assign div_diff  = div_sh - {1'b0, opb_q};
    assign div_ge    = (div_sh >= {1'b0, opb_q});
    assign div_rem_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_q_n   = {lo_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        out_d   = out_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        vld_d   = vld_q;

        if (vld_q && out_ready) vld_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul || (is_div && in2 != '0)) begin
                        state_d = is_mul ? S_MUL : S_DIV;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = '0;
                        lo_d    = in1;
                        opb_d   = in2;
                    end else if (is_div) begin
                        out_d  = '1;
                        hi_d   = in1;
                        zero_d = 1'b0;
                        vld_d  = 1'b1;
                    end else begin
                        out_d  = res;
                        hi_d   = '0;
                        zero_d = (res == '0);
                        vld_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    out_d   = mul_lo_n;
                    hi_d    = mul_acc_n;
                    zero_d  = (mul_lo_n == '0);
                    vld_d   = 1'b1;
                end
            end
            S_DIV: begin
                acc_d = div_rem_n;
                lo_d  = div_q_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    out_d   = div_q_n;
                    hi_d    = div_rem_n;
                    zero_d  = (div_q_n == '0);
                    vld_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [5:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [4:0]   sh = '0;
    logic         in_ready, out_valid, zero, busy;
    logic [W-1:0] dout, dhi;

    alu_seq #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op), .in1(a), .in2(b), .shamt(sh),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(dout), .out_hi(dhi), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   npass = 0;
    int   ntot = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                ntot++;
                $display("FAIL unexpected_result: got out=%h want no result", dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                pop_cyc.push_back(cyc);
                chk("out", 64'(dout), 64'(e.lo));
                chk("out_hi", 64'(dhi), 64'(e.hi));
                chk("zero", 64'(zero), 64'(e.z));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [4:0] s, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic ez, input bit push = 1'b1);
        int t;
        t = 0;
        op = o; a = x; b = y; sh = s; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            ntot++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else if (push) begin
            sb.push_back('{lo: elo, hi: ehi, z: ez});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            ntot++;
            $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic valid_next(input string name);
        @(negedge clk);
        chk(name, 64'(out_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    // Counts busy cycles after an iterative accept; ends at posedge+1.
    task automatic count_busy(input string name, input int want);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            n++;
            @(negedge clk);
        end
        chk(name, 64'(n), 64'(want));
        chk("iter_done_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base, seen;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out", 64'(dout), 64'd0);
        chk("rst_out_hi", 64'(dhi), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-cycle ops
        issue(6'b000000, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1);
        valid_next("addu_latency1");
        issue(6'b000100, 32'd5, 32'd5, 5'd0, 32'h0, 32'h0, 1'b1);
        issue(6'b101010, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 32'h0, 1'b0);
        issue(6'b101001, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1);
        issue(6'b100010, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 32'h0, 1'b0);
        issue(6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234, 32'h0, 1'b0);
        issue(6'b100101, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0, 32'hA5A5_5A5A, 32'h0, 1'b0);
        issue(6'b100110, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'hF0F0_0F0F, 32'h0, 1'b0);
        issue(6'b100111, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        issue(6'b000010, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 32'h0, 1'b0);
        issue(6'b000011, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 32'h0, 1'b0);
        issue(6'b000111, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'h0, 1'b0);
        issue(6'b101011, 32'h1000, 32'h24, 5'd0, 32'h1024, 32'h0, 1'b0);
        issue(6'b111111, 32'h1234, 32'h5678, 5'd0, 32'h0, 32'h0, 1'b1);
        drain();

        // back-to-back stream
        base = pop_cyc.size();
        for (int i = 0; i < 8; i++)
            issue(6'b000000, W'(i), 32'h100, 5'd0, W'(i) + 32'h100, 32'h0, 1'b0);
        drain();
        if (pop_cyc.size() >= base + 8)
            chk("stream_span", 64'(pop_cyc[base+7] - pop_cyc[base]), 64'd7);
        else
            chk("stream_count", 64'(pop_cyc.size() - base), 64'd8);

        // MULTU
        issue(6'b011001, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'hFFFF_FFFE, 32'h1, 1'b0);
        count_busy("mul_busy_cycles", 32);
        issue(6'b011001, 32'h1_0000, 32'h1_0000, 5'd0, 32'h0, 32'h1, 1'b1);
        count_busy("mul2_busy_cycles", 32);
        drain();

        // DIVU
        issue(6'b011011, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0);
        count_busy("div_busy_cycles", 32);
        issue(6'b011011, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd9, 1'b0);
        valid_next("div0_latency1");
        issue(6'b011011, 32'd5, 32'd10, 5'd0, 32'd0, 32'd5, 1'b1);
        count_busy("div3_busy_cycles", 32);
        drain();

        // backpressure
        out_ready = 1'b0;
        issue(6'b000000, 32'h10, 32'h20, 5'd0, 32'h30, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out", 64'(dout), 64'h30);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // flush during DIV
        issue(6'b011011, 32'd100, 32'd7, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // op presented with flush is dropped
        op = 6'b000000; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_drop_op", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // async reset with a held result
        out_ready = 1'b0;
        issue(6'b000000, 32'd3, 32'd4, 5'd0, 32'd7, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_out", 64'(dout), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out", 64'(dout), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // async reset mid-iteration
        issue(6'b011001, 32'd7, 32'd9, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // normal operation after reset
        issue(6'b000000, 32'd40, 32'd2, 5'd0, 32'd42, 32'h0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
